axi_rd_scheduler: RTL



---
 rtl/axi_rd_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/axi_rd_scheduler.sv
// AXI read-address scheduler for a frame fetch: issues generator bursts on AR under
// an outstanding-burst credit limit, assigns rolling ARIDs and checks in-order R completion.
module axi_rd_scheduler #(
  parameter int ID_WIDTH        = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start_pulse,
  input  logic [CNT_WIDTH-1:0]                   total_bursts,
  input  logic                                   req_valid,
  input  logic [ADDR_WIDTH-1:0]                  req_addr,
  input  logic [7:0]                             req_len,
  output logic                                   req_ready,
  output logic [ID_WIDTH-1:0]                    m_axi_arid,
  output logic [ADDR_WIDTH-1:0]                  m_axi_araddr,
  output logic [7:0]                             m_axi_arlen,
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  input  logic [ID_WIDTH-1:0]                    m_axi_rid,
  input  logic [1:0]                             m_axi_rresp,
  input  logic                                   m_axi_rlast,
  input  logic                                   m_axi_rvalid,
  input  logic                                   m_axi_rready,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   rd_error,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW:0] CREDITS = (OW+1)'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] total;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] completed;
  logic [ID_WIDTH-1:0]  next_id;
  logic [ID_WIDTH-1:0]  exp_rid;
  logic                 ar_hs;
  logic                 r_beat;
  logic                 r_last;
  logic                 credit_ret;
  logic                 accept;
  logic [OW:0]          in_flight;

  assign ar_hs      = m_axi_arvalid && m_axi_arready;
  assign r_beat     = m_axi_rvalid && m_axi_rready;
  assign r_last     = r_beat && m_axi_rlast;
  assign credit_ret = r_last && (outstanding != '0);

  // A pending (accepted but not yet handshaken) AR already holds a credit.
  assign in_flight = {1'b0, outstanding} + {{OW{1'b0}}, m_axi_arvalid};
  assign req_ready = (state == RUN) && (!m_axi_arvalid || m_axi_arready) &&
                     (in_flight < CREDITS) && (issued < total);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      total         <= '0;
      issued        <= '0;
      completed     <= '0;
      next_id       <= '0;
      exp_rid       <= '0;
      outstanding   <= '0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_error      <= 1'b0;
    end else if (state == IDLE && start_pulse) begin
      total         <= total_bursts;
      issued        <= '0;
      completed     <= '0;
      next_id       <= '0;
      exp_rid       <= '0;
      outstanding   <= '0;
      m_axi_arvalid <= 1'b0;
      rd_error      <= 1'b0;
      if (total_bursts == '0) begin
        state <= DONE;
        done  <= 1'b1;
      end else begin
        state <= RUN;
        busy  <= 1'b1;
      end
    end else begin
      if (accept) begin
        m_axi_araddr  <= req_addr;
        m_axi_arlen   <= req_len;
        m_axi_arid    <= next_id;
        m_axi_arvalid <= 1'b1;
        issued        <= issued + CNT_WIDTH'(1);
        next_id       <= next_id + ID_WIDTH'(1);
      end else if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
      end

      if (ar_hs && !credit_ret) begin
        outstanding <= outstanding + OW'(1);
      end else if (!ar_hs && credit_ret) begin
        outstanding <= outstanding - OW'(1);
      end

      if (r_last) begin
        exp_rid   <= exp_rid + ID_WIDTH'(1);
        completed <= completed + CNT_WIDTH'(1);
      end

      // Errors are recorded but never stall sequencing.
      if ((r_beat && m_axi_rresp != 2'b00) ||
          (r_last && (m_axi_rid != exp_rid || outstanding == '0))) begin
        rd_error <= 1'b1;
      end

      case (state)
        RUN: begin
          if (issued == total && !m_axi_arvalid) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0 && completed >= issued) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
